// File: rtl/reset_sequencer.sv
// Power-on / reset sequencer: waits for PLL locks, holds reset, then releases
// the reset domains in staggered order; re-enters reset on lock loss or a button event.
module reset_sequencer #(
  parameter int NUM_LOCKS       = 2,
  parameter int NUM_OUTS        = 3,
  parameter int HOLD_CYCLES     = 31,
  parameter int STAGGER_CYCLES  = 4,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int SEL_WIDTH       = 4,
  parameter int SEL_CODE        = 1
) (
  input  logic                 clk,
  input  logic                 reset_i,
  input  logic [NUM_LOCKS-1:0] locked_i,
  input  logic                 btn_i,
  input  logic [SEL_WIDTH-1:0] sel_i,
  output logic [NUM_OUTS-1:0]  reset_o,
  output logic                 ready_o,
  output logic [1:0]           cause_o
);

  localparam int REL_SPAN = (NUM_OUTS - 1) * STAGGER_CYCLES;
  localparam int CNT_MAX  = (HOLD_CYCLES > REL_SPAN) ? HOLD_CYCLES : REL_SPAN;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int DB_W     = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [CNT_W-1:0]     HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]     REL_LAST  = CNT_W'(REL_SPAN);
  localparam logic [DB_W-1:0]      DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SEL_WIDTH-1:0] SEL_MATCH = SEL_WIDTH'(SEL_CODE);

  localparam logic [1:0] CAUSE_POR  = 2'd0;
  localparam logic [1:0] CAUSE_LOCK = 2'd1;
  localparam logic [1:0] CAUSE_BTN  = 2'd2;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t               state_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [NUM_OUTS-1:0]  reset_r;
  logic                 ready_r;
  logic [1:0]           cause_r;

  logic [NUM_LOCKS-1:0] lock_meta_r;
  logic [NUM_LOCKS-1:0] lock_sync_r;
  logic                 btn_meta_r;
  logic                 btn_sync_r;
  logic                 btn_db_r;
  logic                 btn_db_d_r;
  logic [DB_W-1:0]      db_cnt_r;

  logic                 all_locked_s;
  logic                 btn_evt_s;
  logic                 fault_s;
  logic [CNT_W-1:0]     cnt_inc_s;
  logic [NUM_OUTS-1:0]  rel_clear_s;

  assign all_locked_s = &lock_sync_r;
  assign btn_evt_s    = btn_db_r & ~btn_db_d_r & (sel_i == SEL_MATCH);
  assign fault_s      = (state_r != WAIT_LOCK);
  assign cnt_inc_s    = cnt_r + CNT_W'(1);

  assign reset_o = reset_r;
  assign ready_o = ready_r;
  assign cause_o = cause_r;

  // Domain k (k>=1) is released on the edge where the release counter reaches k*STAGGER
  always_comb begin
    rel_clear_s = '0;
    for (int k = 1; k < NUM_OUTS; k++) begin
      rel_clear_s[k] = (cnt_inc_s == CNT_W'(k * STAGGER_CYCLES));
    end
  end

  // Two-flop synchronisers for the asynchronous lock and button inputs
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      lock_meta_r <= '0;
      lock_sync_r <= '0;
      btn_meta_r  <= 1'b0;
      btn_sync_r  <= 1'b0;
    end else begin
      lock_meta_r <= locked_i;
      lock_sync_r <= lock_meta_r;
      btn_meta_r  <= btn_i;
      btn_sync_r  <= btn_meta_r;
    end
  end

  // Button debouncer: any bounce back to the current level restarts the count
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      btn_db_r   <= 1'b0;
      btn_db_d_r <= 1'b0;
      db_cnt_r   <= '0;
    end else begin
      btn_db_d_r <= btn_db_r;
      if (btn_sync_r != btn_db_r) begin
        if (db_cnt_r == DB_LAST) begin
          btn_db_r <= btn_sync_r;
          db_cnt_r <= '0;
        end else begin
          db_cnt_r <= db_cnt_r + DB_W'(1);
        end
      end else begin
        db_cnt_r <= '0;
      end
    end
  end

  // Sequencer FSM; lock loss outranks a simultaneous button event
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_r <= WAIT_LOCK;
      cnt_r   <= '0;
      reset_r <= '1;
      ready_r <= 1'b0;
      cause_r <= CAUSE_POR;
    end else if (fault_s && !all_locked_s) begin
      state_r <= WAIT_LOCK;
      cnt_r   <= '0;
      reset_r <= '1;
      ready_r <= 1'b0;
      cause_r <= CAUSE_LOCK;
    end else if (fault_s && btn_evt_s) begin
      // PLLs are still locked, so go straight back to the hold phase
      state_r <= HOLD;
      cnt_r   <= '0;
      reset_r <= '1;
      ready_r <= 1'b0;
      cause_r <= CAUSE_BTN;
    end else begin
      case (state_r)
        WAIT_LOCK: begin
          reset_r <= '1;
          ready_r <= 1'b0;
          cnt_r   <= '0;
          if (all_locked_s) begin
            state_r <= HOLD;
          end
        end
        HOLD: begin
          if (cnt_r == HOLD_LAST) begin
            state_r    <= RELEASE;
            cnt_r      <= '0;
            reset_r[0] <= 1'b0;
          end else begin
            cnt_r <= cnt_inc_s;
          end
        end
        RELEASE: begin
          if (cnt_r == REL_LAST) begin
            state_r <= RUN;
            ready_r <= 1'b1;
          end else begin
            cnt_r   <= cnt_inc_s;
            reset_r <= reset_r & ~rel_clear_s;
          end
        end
        RUN: begin
          ready_r <= 1'b1;
        end
        default: begin
          state_r <= WAIT_LOCK;
          cnt_r   <= '0;
          reset_r <= '1;
          ready_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed test-plan steps plus random
// lock glitches and button presses, compared every cycle with a timeline model.
module tb_reset_sequencer;

  localparam int NL = 2;
  localparam int NO = 3;
  localparam int H  = 31;
  localparam int S  = 4;
  localparam int D  = 8;
  localparam int SW = 4;
  localparam int SC = 1;
  localparam logic [NO-1:0] ALL1 = '1;

  logic          clk = 1'b0;
  logic          reset_i;
  logic [NL-1:0] locked_i;
  logic          btn_i;
  logic [SW-1:0] sel_i;
  logic [NO-1:0] reset_o;
  logic          ready_o;
  logic [1:0]    cause_o;

  int vectors     = 0;
  int miscompares = 0;
  int tick_n      = 0;

  // Reference model: edge count, edge of the last HOLD entry (-1 = waiting for locks),
  // synchroniser delay lines and a window of recent synchronised button samples.
  int            m_edge;
  int            m_hold;
  logic [1:0]    m_cause;
  logic [NL-1:0] m_lk [2];
  logic          m_bt [2];
  logic          m_win [$];
  logic          m_db;
  logic          m_db_prev;

  always #5 clk = ~clk;

  reset_sequencer #(
    .NUM_LOCKS(NL), .NUM_OUTS(NO), .HOLD_CYCLES(H), .STAGGER_CYCLES(S),
    .DEBOUNCE_CYCLES(D), .SEL_WIDTH(SW), .SEL_CODE(SC)
  ) dut (
    .clk      (clk),
    .reset_i  (reset_i),
    .locked_i (locked_i),
    .btn_i    (btn_i),
    .sel_i    (sel_i),
    .reset_o  (reset_o),
    .ready_o  (ready_o),
    .cause_o  (cause_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [NO-1:0] exp_rst();
    logic [NO-1:0] r;
    r = ALL1;
    if (m_hold >= 0) begin
      for (int k = 0; k < NO; k++) r[k] = ((m_edge - m_hold) < (H + k * S));
    end
    return r;
  endfunction

  function automatic logic exp_rdy();
    return (m_hold >= 0) && ((m_edge - m_hold) >= (H + (NO - 1) * S + 1));
  endfunction

  task automatic model_reset();
    m_edge = 0; m_hold = -1; m_cause = 2'd0;
    m_lk[0] = '0; m_lk[1] = '0; m_bt[0] = 1'b0; m_bt[1] = 1'b0;
    m_win.delete();
    m_db = 1'b0; m_db_prev = 1'b0;
  endtask

  task automatic model_step(input logic [NL-1:0] lk, input logic bt, input logic [SW-1:0] sl);
    logic all_lk, evt, differ;
    all_lk = &m_lk[1];
    evt    = m_db && !m_db_prev && (sl == SW'(SC));
    m_edge++;
    if (m_hold < 0) begin
      if (all_lk) m_hold = m_edge;
    end else if (!all_lk) begin
      m_hold = -1; m_cause = 2'd1;
    end else if (evt) begin
      m_hold = m_edge; m_cause = 2'd2;
    end
    // debounced level flips once the last D synchronised samples all disagree with it
    m_db_prev = m_db;
    m_win.push_back(m_bt[1]);
    if (m_win.size() > D) void'(m_win.pop_front());
    if (m_win.size() == D) begin
      differ = 1'b1;
      foreach (m_win[i]) if (m_win[i] == m_db) differ = 1'b0;
      if (differ) m_db = !m_db;
    end
    m_lk[1] = m_lk[0]; m_lk[0] = lk;
    m_bt[1] = m_bt[0]; m_bt[0] = bt;
  endtask

  task automatic tick();
    logic [NL-1:0] lk;
    logic          bt;
    logic [SW-1:0] sl;
    lk = locked_i; bt = btn_i; sl = sel_i;
    @(posedge clk);
    model_step(lk, bt, sl);
    tick_n++;
    #1;
    chk("reset_o", 32'(reset_o), 32'(exp_rst()));
    chk("ready_o", 32'(ready_o), 32'(exp_rdy()));
    chk("cause_o", 32'(cause_o), 32'(m_cause));
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    #1;
    chk("async_rst_reset_o", 32'(reset_o), 32'(ALL1));
    chk("async_rst_ready_o", 32'(ready_o), 32'd0);
    chk("async_rst_cause_o", 32'(cause_o), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_held_reset_o", 32'(reset_o), 32'(ALL1));
    chk("rst_held_ready_o", 32'(ready_o), 32'd0);
    reset_i = 1'b0;
  endtask

  // what: 0..NO-1 = that domain released, NO = ready high, NO+1 = all domains in reset
  task automatic wait_for(input int what, output int at);
    logic done;
    at = -1;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      tick();
      if (what < NO) done = (reset_o[what] === 1'b0);
      else if (what == NO) done = (ready_o === 1'b1);
      else done = (reset_o === ALL1);
      if (done) at = tick_n;
    end
  endtask

  initial begin
    #600000;
    $display("FAIL timeout: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    int t0, at, hold_at, len;
    reset_i = 1'b1; locked_i = '0; btn_i = 1'b0; sel_i = SW'(SC);
    model_reset();
    #2;
    do_reset();
    repeat (3) tick();

    // power-on with both locks present
    locked_i = 2'b11; t0 = tick_n;
    wait_for(0, at);  chk("por_rst0_edges", 32'(at - (t0 + 1)), 32'd33);
    wait_for(1, at);  chk("por_rst1_edges", 32'(at - (t0 + 1)), 32'd37);
    wait_for(2, at);  chk("por_rst2_edges", 32'(at - (t0 + 1)), 32'd41);
    wait_for(NO, at); chk("por_ready_edges", 32'(at - (t0 + 1)), 32'd42);
    chk("por_cause", 32'(cause_o), 32'd0);

    // partial lock keeps everything in reset
    do_reset();
    locked_i = 2'b01;
    repeat (100) tick();
    chk("partial_lock_hold", 32'(reset_o), 32'(ALL1));
    locked_i = 2'b11; t0 = tick_n;
    wait_for(0, at);  chk("partial_rst0_edges", 32'(at - (t0 + 1)), 32'd33);
    wait_for(NO, at); chk("partial_ready_edges", 32'(at - (t0 + 1)), 32'd42);

    // one-cycle lock loss while running
    locked_i = 2'b10; t0 = tick_n;
    tick();
    locked_i = 2'b11;
    wait_for(NO + 1, at); chk("lockloss_latency", 32'(at - t0), 32'd3);
    chk("lockloss_cause", 32'(cause_o), 32'd1);
    wait_for(NO, at);
    chk("lockloss_recovered_cause", 32'(cause_o), 32'd1);

    // bouncy 20-cycle press with the arming selector
    sel_i = SW'(SC); hold_at = -1;
    for (int i = 0; i < 20; i++) begin
      btn_i = (i == 1) ? 1'b0 : 1'b1;
      tick();
      if (hold_at < 0 && reset_o === ALL1) hold_at = tick_n;
    end
    btn_i = 1'b0;
    chk("btn_event_seen", 32'(hold_at >= 0), 32'd1);
    wait_for(0, at);  chk("btn_rst0_edges", 32'(at - hold_at), 32'd31);
    wait_for(1, at);  chk("btn_rst1_edges", 32'(at - hold_at), 32'd35);
    wait_for(2, at);  chk("btn_rst2_edges", 32'(at - hold_at), 32'd39);
    wait_for(NO, at); chk("btn_ready_edges", 32'(at - hold_at), 32'd40);
    chk("btn_cause", 32'(cause_o), 32'd2);

    // a 5-cycle press is too short to register
    btn_i = 1'b1; repeat (5) tick(); btn_i = 1'b0;
    repeat (30) tick();
    chk("short_press_ready", 32'(ready_o), 32'd1);

    // debounced press with a non-arming selector
    sel_i = SW'(2);
    btn_i = 1'b1; repeat (20) tick(); btn_i = 1'b0;
    repeat (20) tick();
    chk("wrong_sel_ready", 32'(ready_o), 32'd1);
    chk("wrong_sel_cause", 32'(cause_o), 32'd2);
    sel_i = SW'(SC);

    // lock loss and button event reach the sequencer on the same edge
    btn_i = 1'b1; repeat (8) tick();
    locked_i = 2'b01; repeat (3) tick();
    chk("simul_reset_o", 32'(reset_o), 32'(ALL1));
    locked_i = 2'b11; repeat (10) tick();
    btn_i = 1'b0;
    chk("simul_cause", 32'(cause_o), 32'd1);

    // reset_i mid-release acts immediately
    wait_for(0, at);
    tick(); tick();
    #2;
    do_reset();
    wait_for(NO, at);
    chk("after_rst_cause", 32'(cause_o), 32'd0);

    // random lock glitches and button presses
    for (int it = 0; it < 12; it++) begin
      case ($urandom_range(0, 2))
        0: begin
          locked_i = NL'($urandom_range(0, 2));
          repeat ($urandom_range(1, 6)) tick();
          locked_i = 2'b11;
        end
        1: begin
          sel_i = ($urandom_range(0, 1) == 1) ? SW'(SC) : SW'(2);
          len = $urandom_range(3, 25);
          for (int i = 0; i < len; i++) begin
            btn_i = (i < 3) ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
          end
          btn_i = 1'b0;
        end
        default: begin
          sel_i = SW'($urandom_range(0, 3));
        end
      endcase
      repeat ($urandom_range(10, 60)) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
